// File: rtl/fifo_ram_reader.sv
// fifo_ram_reader: streams words out of a FIFO RAM through a 3-entry buffer, tolerating 1- or 2-cycle RAM latency.
// Define FIFO_RDR_ECC_FLAG_EN to carry R_DB_DETECT alongside each word and expose it as DERR.
module fifo_ram_reader #(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 7,
  parameter int LATENCY = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [AWIDTH:0]   WR_PTR,
  input  logic              FLUSH,
  output logic              R_EN,
  output logic [AWIDTH-1:0] R_ADDR,
  input  logic [WIDTH-1:0]  R_DATA,
  input  logic              R_DB_DETECT,
  output logic [AWIDTH:0]   RD_PTR,
  output logic              EMPTY,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DVALID,
  input  logic              DREADY
`ifdef FIFO_RDR_ECC_FLAG_EN
  ,
  output logic              DERR
`endif
);
`ifdef FIFO_RDR_ECC_FLAG_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif
  logic [AWIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [BW-1:0]    buf_q [3];
  logic [BW-1:0]    buf_d [3];
  logic [BW-1:0]    entry;
  logic [1:0]       inflight, tail;
  logic             pop, ret, cap;
`ifdef FIFO_RDR_ECC_FLAG_EN
  assign entry = {R_DB_DETECT, R_DATA};
  assign DERR  = buf_q[0][WIDTH];
`else
  logic unused_db;
  assign entry     = R_DATA;
  assign unused_db = R_DB_DETECT;
`endif
  assign RD_PTR = rd_ptr_q;
  assign R_ADDR = rd_ptr_q[AWIDTH-1:0];
  assign DVALID = cnt_q != 2'd0;
  assign DOUT   = buf_q[0][WIDTH-1:0];
  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + {1'b0, vld_q[i]};
    pop      = DVALID & DREADY;
    ret      = vld_q[LATENCY-1];
    cap      = ret & ~FLUSH;
    EMPTY    = rd_ptr_q == WR_PTR;
    // Reserve buffer space for every read still travelling through the RAM pipeline
    R_EN     = ~RESET & ~EMPTY & ~FLUSH &
               (({1'b0, cnt_q} + {1'b0, inflight} - {2'b00, pop}) < 3'd3);
    rd_ptr_d = FLUSH ? WR_PTR : rd_ptr_q + {{AWIDTH{1'b0}}, R_EN};
    vld_d    = FLUSH ? '0 : (vld_q << 1) | LATENCY'(R_EN);
    tail     = cnt_q - {1'b0, pop};
    cnt_d    = FLUSH ? 2'd0 : tail + {1'b0, cap};
    for (int i = 0; i < 3; i++)
      buf_d[i] = (cap && tail == 2'(i)) ? entry :
                 pop ? buf_q[(i == 2) ? 2 : i + 1] : buf_q[i];
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_ptr_q <= '0;
      cnt_q    <= 2'd0;
      vld_q    <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end
  assert property (@(posedge CLOCK) disable iff (RESET) !(cap && tail == 2'd3));
endmodule

// File: tb/tb_fifo_ram_reader.sv
// tb_fifo_ram_reader: directed checks of fifo_ram_reader at LATENCY=2 (u0) and LATENCY=1 (u1).
module tb_fifo_ram_reader;
  localparam int W  = 32;
  localparam int AW = 7;
  logic          clk = 1'b0;
  logic          rst, flush, dready;
  logic [AW:0]   wr_ptr;
  logic          r_en0, empty0, dvalid0, db_s0, db0;
  logic          r_en1, empty1, dvalid1, db1;
  logic [AW-1:0] r_addr0, r_addr1;
  logic [AW:0]   rd_ptr0, rd_ptr1;
  logic [W-1:0]  s0, r_data0, r_data1, dout0, dout1;
  logic [W-1:0]  ram [128];
  int            err_addr;
  int            n_chk = 0;
  int            n_fail = 0;
`ifdef FIFO_RDR_ECC_FLAG_EN
  logic          derr0, derr1;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) begin
    s0      <= ram[r_addr0];
    db_s0   <= int'(r_addr0) == err_addr;
    r_data0 <= s0;
    db0     <= db_s0;
    r_data1 <= ram[r_addr1];
    db1     <= int'(r_addr1) == err_addr;
  end
  fifo_ram_reader #(.WIDTH(W), .AWIDTH(AW), .LATENCY(2)) u0 (
    .CLOCK(clk), .RESET(rst), .WR_PTR(wr_ptr), .FLUSH(flush), .R_EN(r_en0), .R_ADDR(r_addr0),
    .R_DATA(r_data0), .R_DB_DETECT(db0), .RD_PTR(rd_ptr0), .EMPTY(empty0), .DOUT(dout0),
    .DVALID(dvalid0), .DREADY(dready)
`ifdef FIFO_RDR_ECC_FLAG_EN
    , .DERR(derr0)
`endif
  );
  fifo_ram_reader #(.WIDTH(W), .AWIDTH(AW), .LATENCY(1)) u1 (
    .CLOCK(clk), .RESET(rst), .WR_PTR(wr_ptr), .FLUSH(flush), .R_EN(r_en1), .R_ADDR(r_addr1),
    .R_DATA(r_data1), .R_DB_DETECT(db1), .RD_PTR(rd_ptr1), .EMPTY(empty1), .DOUT(dout1),
    .DVALID(dvalid1), .DREADY(dready)
`ifdef FIFO_RDR_ECC_FLAG_EN
    , .DERR(derr1)
`endif
  );
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_ptr = '0; flush = 1'b0; dready = 1'b0; err_addr = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr_ptr = 8'h10; flush = 1'b0; dready = 1'b1; err_addr = -1;
    #1;
    n_chk++; if (rd_ptr0 !== 8'h00) begin n_fail++; $display("FAIL reset_rdptr got %h exp 00", rd_ptr0); end
    n_chk++; if (dvalid0 !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid got %b exp 0", dvalid0); end
    n_chk++; if (dout0 !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout0); end
    n_chk++; if (r_en0 !== 1'b0) begin n_fail++; $display("FAIL reset_ren0 got %b exp 0", r_en0); end
    n_chk++; if (r_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_ren1 got %b exp 0", r_en1); end
    n_chk++; if (empty0 !== 1'b0) begin n_fail++; $display("FAIL reset_empty got %b exp 0", empty0); end
    do_reset();
  endtask
  task automatic test_stream();
    do_reset();
    wr_ptr = 8'd5; dready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++; if (r_en0 !== (c < 5)) begin n_fail++; $display("FAIL stream_ren c=%0d got %b exp %b", c, r_en0, c < 5); end
      if (c < 5) begin
        n_chk++; if (r_addr0 !== 7'(c)) begin n_fail++; $display("FAIL stream_addr c=%0d got %0d exp %0d", c, r_addr0, c); end
      end
      n_chk++; if (dvalid0 !== (c >= 3 && c < 8)) begin n_fail++; $display("FAIL stream_dvalid c=%0d got %b", c, dvalid0); end
      if (c >= 3 && c < 8) begin
        n_chk++; if (dout0 !== ram[c-3]) begin n_fail++; $display("FAIL stream_dout c=%0d got %h exp %h", c, dout0, ram[c-3]); end
      end
      @(negedge clk);
    end
    #1;
    n_chk++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b exp 1", empty0); end
    n_chk++; if (rd_ptr0 !== 8'd5) begin n_fail++; $display("FAIL stream_rdptr got %h exp 05", rd_ptr0); end
  endtask
  task automatic test_stall();
    int n = 0;
    do_reset();
    wr_ptr = 8'd10; dready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n += int'(r_en0);
      if (c >= 4) begin
        n_chk++; if (dvalid0 !== 1'b1 || dout0 !== ram[0]) begin n_fail++; $display("FAIL stall_hold c=%0d got %b/%h exp 1/%h", c, dvalid0, dout0, ram[0]); end
      end
      @(negedge clk);
    end
    n_chk++; if (n !== 3) begin n_fail++; $display("FAIL stall_reads got %0d exp 3", n); end
    dready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      n_chk++; if (dvalid0 !== (k < 10)) begin n_fail++; $display("FAIL drain_dvalid k=%0d got %b", k, dvalid0); end
      if (k < 10) begin
        n_chk++; if (dout0 !== ram[k]) begin n_fail++; $display("FAIL drain_dout k=%0d got %h exp %h", k, dout0, ram[k]); end
      end
      @(negedge clk);
    end
  endtask
  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{7'd126, 7'd127, 7'd0, 7'd1};
    do_reset();
    wr_ptr = 8'h7E; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_chk++; if (rd_ptr0 !== 8'h7E) begin n_fail++; $display("FAIL wrap_flushptr got %h exp 7e", rd_ptr0); end
    n_chk++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL wrap_empty0 got %b exp 1", empty0); end
    @(negedge clk);
    wr_ptr = 8'h82; dready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      n_chk++; if (r_en0 !== (c < 4)) begin n_fail++; $display("FAIL wrap_ren c=%0d got %b", c, r_en0); end
      if (c < 4) begin
        n_chk++; if (r_addr0 !== exp_a[c]) begin n_fail++; $display("FAIL wrap_addr c=%0d got %0d exp %0d", c, r_addr0, exp_a[c]); end
      end
      if (c >= 3 && c < 7) begin
        n_chk++; if (dvalid0 !== 1'b1 || dout0 !== ram[exp_a[c-3]]) begin n_fail++; $display("FAIL wrap_dout c=%0d got %b/%h exp 1/%h", c, dvalid0, dout0, ram[exp_a[c-3]]); end
      end
      @(negedge clk);
    end
    #1;
    n_chk++; if (rd_ptr0 !== 8'h82) begin n_fail++; $display("FAIL wrap_rdptr got %h exp 82", rd_ptr0); end
    n_chk++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty0); end
  endtask
  task automatic test_flush();
    do_reset();
    wr_ptr = 8'h20; dready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      @(negedge clk);
    end
    #1;
    n_chk++; if (dvalid0 !== 1'b1 || dout0 !== ram[0]) begin n_fail++; $display("FAIL flush_pre got %b/%h exp 1/%h", dvalid0, dout0, ram[0]); end
    flush = 1'b1;
    #1;
    n_chk++; if (r_en0 !== 1'b0) begin n_fail++; $display("FAIL flush_ren got %b exp 0", r_en0); end
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++; if (dvalid0 !== 1'b0) begin n_fail++; $display("FAIL flush_dvalid c=%0d got %b exp 0", c, dvalid0); end
      n_chk++; if (rd_ptr0 !== 8'h20 || empty0 !== 1'b1 || r_en0 !== 1'b0) begin n_fail++; $display("FAIL flush_ptr c=%0d got %h/%b/%b exp 20/1/0", c, rd_ptr0, empty0, r_en0); end
      @(negedge clk);
    end
  endtask
`ifdef FIFO_RDR_ECC_FLAG_EN
  task automatic test_ecc();
    do_reset();
    err_addr = 2; wr_ptr = 8'd5; dready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c >= 3 && c < 8) begin
        n_chk++; if (derr0 !== (c == 5) || dout0 !== ram[c-3]) begin n_fail++; $display("FAIL ecc_derr c=%0d got %b/%h exp %b/%h", c, derr0, dout0, c == 5, ram[c-3]); end
      end
      @(negedge clk);
    end
  endtask
`endif
  task automatic test_reset_mid();
    do_reset();
    wr_ptr = 8'd20; dready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      @(negedge clk);
    end
    #1;
    n_chk++; if (r_en1 !== 1'b1 || rd_ptr1 !== 8'd3) begin n_fail++; $display("FAIL mid_pre got %b/%h exp 1/03", r_en1, rd_ptr1); end
    n_chk++; if (dvalid1 !== 1'b1 || dout1 !== ram[1]) begin n_fail++; $display("FAIL mid_dout got %b/%h exp 1/%h", dvalid1, dout1, ram[1]); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (rd_ptr1 !== 8'd0) begin n_fail++; $display("FAIL mid_rdptr got %h exp 00", rd_ptr1); end
    n_chk++; if (dvalid1 !== 1'b0 || r_en1 !== 1'b0) begin n_fail++; $display("FAIL mid_clear got %b/%b exp 0/0", dvalid1, r_en1); end
    n_chk++; if (dout1 !== '0) begin n_fail++; $display("FAIL mid_dout0 got %h exp 0", dout1); end
    @(negedge clk);
    wr_ptr = '0;
    @(negedge clk);
    rst = 1'b0;
    wr_ptr = 8'd1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (dvalid1 !== (c == 2)) begin n_fail++; $display("FAIL mid_resume c=%0d got %b", c, dvalid1); end
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0103;
    rst = 1'b1; wr_ptr = '0; flush = 1'b0; dready = 1'b0; err_addr = -1;
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_flush();
`ifdef FIFO_RDR_ECC_FLAG_EN
    test_ecc();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_ram_reader.md
FIFO_RAM_READER -- requirements
Module: fifo_ram_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7: RAM address width (depth 2^AWIDTH = 128).
REQ-003 SHALL have parameter LATENCY, default 2: RAM read latency in cycles, R_EN to R_DATA; legal values 1 (non-pipelined RAM) and 2 (pipelined RAM).
REQ-004 SHALL have port CLOCK, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port WR_PTR, input, AWIDTH+1: writer pointer, same clock; MSB is the wrap bit.
REQ-007 SHALL have port FLUSH, input, 1: synchronous discard of all unread data.
REQ-008 SHALL have port R_EN, output, 1: RAM read enable.
REQ-009 SHALL have port R_ADDR, output, AWIDTH: RAM read address.
REQ-010 SHALL have port R_DATA, input, WIDTH: RAM read data, valid LATENCY cycles after R_EN.
REQ-011 SHALL have port R_DB_DETECT, input, 1: RAM double-bit error flag, aligned with R_DATA.
REQ-012 SHALL have port RD_PTR, output, AWIDTH+1: registered read pointer returned to the writer for full detection.
REQ-013 SHALL have port EMPTY, output, 1: high when RD_PTR == WR_PTR.
REQ-014 SHALL have port DOUT, output, WIDTH: stream data.
REQ-015 SHALL have port DVALID, output, 1: DOUT valid.
REQ-016 SHALL have port DREADY, input, 1: consumer accepts DOUT.
REQ-017 SHALL have port DERR, output, 1: DOUT word carried a double-bit error (present only with the macro in REQ-033).

Function
REQ-018 SHALL transfer a word only on a cycle with DVALID=1 and DREADY=1 (pop).
REQ-019 SHALL hold DOUT/DVALID stable while DVALID=1 and DREADY=0.
REQ-020 SHALL keep a 3-entry output buffer in order; DOUT is the head entry; DVALID = (occupancy != 0).
REQ-021 SHALL track inflight = R_EN pulses issued but not yet returned (0..LATENCY) with a LATENCY-deep valid shift register.
REQ-022 SHALL issue a read (R_EN=1, combinational) when EMPTY=0, FLUSH=0 and occupancy + inflight - pop < 3.
REQ-023 SHALL drive R_ADDR = RD_PTR[AWIDTH-1:0] and increment RD_PTR modulo 2^(AWIDTH+1) on every issue; R_ADDR wraps from 127 to 0 and the wrap bit toggles.
REQ-024 SHALL write R_DATA into the buffer tail exactly LATENCY cycles after the issuing R_EN; capture and pop in the same cycle are both honoured.
REQ-025 SHALL sustain one word per cycle with DREADY held high and WR_PTR ahead of RD_PTR, for both LATENCY values.
REQ-026 SHALL produce first-word latency LATENCY+1 cycles from EMPTY falling to DVALID rising, when the buffer is empty.
REQ-027 SHALL never overflow the buffer: a write into a full buffer is a design error, flagged by assertion in simulation.
REQ-028 SHALL on FLUSH=1: set RD_PTR <= WR_PTR, clear occupancy and the in-flight shift register, drop returning data, and force DVALID=0 next cycle; a pop coincident with FLUSH is accepted.
REQ-029 SHALL compute EMPTY combinationally from RD_PTR and WR_PTR, including the wrap bit.

Reset
REQ-030 SHALL on RESET=1 asynchronously clear RD_PTR=0, occupancy=0, in-flight register=0, DOUT=0, DVALID=0, DERR=0; R_EN evaluates to 0 while RESET=1.
REQ-031 SHALL, on reset deassertion mid-transfer, lose all in-flight and buffered words; the writer is reset together with this block.
REQ-032 SHALL resume normal operation on the first rising CLOCK edge after RESET falls.

Configuration
REQ-033 SHALL compile the error path only when FIFO_RDR_ECC_FLAG_EN is defined: buffer width WIDTH+1 capturing R_DB_DETECT, DERR = head entry flag.
REQ-034 SHALL, without FIFO_RDR_ECC_FLAG_EN, omit the DERR port, ignore R_DB_DETECT, and keep buffer width at WIDTH.

Verification
REQ-035 SHALL cover: reset, WR_PTR=5, DREADY=1, LATENCY=2 -> R_EN at addresses 0..4, DVALID high on cycle 3 after EMPTY falls, DOUT = RAM[0..4] back-to-back, then EMPTY=1.
REQ-036 SHALL cover: DREADY=0 with 10 words available -> exactly 3 reads issued, DOUT=RAM[0] held; DREADY=1 -> the remaining 7 words follow with no gap.
REQ-037 SHALL cover: RD_PTR=0x7E, WR_PTR=0x82 -> R_ADDR sequence 126,127,0,1; RD_PTR ends at 0x82 with the wrap bit set; EMPTY=1.
REQ-038 SHALL cover: FLUSH during 2 in-flight reads with WR_PTR=0x20 -> DVALID=0 next cycle, RD_PTR=0x20, and no stale word appears afterwards.
REQ-039 SHALL cover: with FIFO_RDR_ECC_FLAG_EN, R_DB_DETECT=1 on the third returned word -> DERR=1 only while that word is at DOUT.
REQ-040 SHALL cover: RESET asserted mid-burst (LATENCY=1) -> DVALID, R_EN and RD_PTR clear immediately without a clock edge.
